bb_sgpio_target: RTL

// - SGPIO target (receiver) for the baseboard CPLD: decodes the serial drive-LED stream (SCLK/SLOAD/SDATA)

---
 rtl/bb_sgpio_target_if.sv | 10 +
 rtl/bb_sgpio_target.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bb_sgpio_target_if.sv
// SGPIO serial link from the initiator to the target.
// Carries the SCLK, SLOAD and SDATAOUT lines.
interface bb_sgpio_target_if;
  logic SGPIO_CK_IN;
  logic SGPIO_LD_IN;
  logic SGPIO_DATA_IN;

  modport master (output SGPIO_CK_IN, SGPIO_LD_IN, SGPIO_DATA_IN);
  modport slave  (input  SGPIO_CK_IN, SGPIO_LD_IN, SGPIO_DATA_IN);
endinterface

// File: rtl/bb_sgpio_target.sv
// SGPIO target: decodes the serial drive-LED stream into per-drive active-low ACT/LOC/FAIL outputs.
// Define SGPIO_LOCFAIL_EN to decode LOC/FAIL; otherwise only ACT is decoded and LOC/FAIL outputs stay all-ones.
module bb_sgpio_target #(
  parameter int HDD_NUM     = 36,
  parameter int TIMEOUT_CYC = 250000
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  bb_sgpio_target_if.slave   sgpio,
  output logic [HDD_NUM-1:0] DRV_ACT_LED_N,
  output logic [HDD_NUM-1:0] DRV_LOC_LED_N,
  output logic [HDD_NUM-1:0] DRV_FAIL_LED_N,
  output logic               FRAME_OK,
  output logic               FRAME_ERR,
  output logic               LINK_UP
);
  localparam int FLEN = 3 * HDD_NUM;
  localparam int CW   = $clog2(FLEN + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int DW   = (HDD_NUM > 1) ? $clog2(HDD_NUM) : 1;

  localparam logic [CW-1:0] LAST_BIT = CW'(FLEN - 1);
  localparam logic [CW-1:0] FLEN_CNT = CW'(FLEN);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {SYNC, RECV, OVERRUN} state_t;

  state_t             state_q, state_d;
  logic               ck_s1, ck_s2, ld_s1, ld_s2, data_s1, data_s2;
  logic [2:0]         ck_hist;
  logic               ck_fall, timeout_hit;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      drv_q, drv_d;
  logic [1:0]         fld_q, fld_d;
  logic [TW-1:0]      to_q;
  logic               store, commit, err;
  logic [HDD_NUM-1:0] act_sh, act_nx;

  // Two-flop synchronizers plus a short history of the synced clock for edge qualification
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ck_s1   <= 1'b0;
      ck_s2   <= 1'b0;
      ld_s1   <= 1'b0;
      ld_s2   <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
      ck_hist <= '0;
    end else begin
      ck_s1   <= sgpio.SGPIO_CK_IN;
      ck_s2   <= ck_s1;
      ld_s1   <= sgpio.SGPIO_LD_IN;
      ld_s2   <= ld_s1;
      data_s1 <= sgpio.SGPIO_DATA_IN;
      data_s2 <= data_s1;
      ck_hist <= {ck_hist[1:0], ck_s2};
    end
  end

  // Requiring two highs then two lows rejects single-cycle glitches on SCLK
  assign ck_fall     = ({ck_hist, ck_s2} == 4'b1100);
  assign timeout_hit = !ck_fall && (to_q == TO_LAST);

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N)             to_q <= '0;
    else if (ck_fall)         to_q <= '0;
    else if (to_q != TO_MAX)  to_q <= to_q + 1'b1;
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      drv_q   <= '0;
      fld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      fld_q   <= fld_d;
    end
  end

  // drv/fld track cnt as drive index and position within the 3-bit group, avoiding a divider
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    fld_d   = fld_q;
    store   = 1'b0;
    commit  = 1'b0;
    err     = 1'b0;
    if (timeout_hit) begin
      state_d = SYNC;
      cnt_d   = '0;
      drv_d   = '0;
      fld_d   = '0;
    end else if (ck_fall) begin
      unique case (state_q)
        SYNC: begin
          if (ld_s2) begin
            state_d = RECV;
            cnt_d   = '0;
            drv_d   = '0;
            fld_d   = '0;
          end
        end
        RECV: begin
          store = 1'b1;
          if (ld_s2) begin
            if (cnt_q == LAST_BIT) commit = 1'b1;
            else                   err    = 1'b1;
            cnt_d = '0;
            drv_d = '0;
            fld_d = '0;
          end else if (cnt_q == LAST_BIT) begin
            state_d = OVERRUN;
            cnt_d   = FLEN_CNT;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (fld_q == 2'd2) begin
              fld_d = '0;
              drv_d = drv_q + 1'b1;
            end else begin
              fld_d = fld_q + 1'b1;
            end
          end
        end
        OVERRUN: begin
          if (ld_s2) begin
            err     = 1'b1;
            state_d = RECV;
            cnt_d   = '0;
            drv_d   = '0;
            fld_d   = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // Commit uses the next shadow value so the final bit of the frame is included
  always_comb begin
    act_nx = act_sh;
    if (store && (fld_q == 2'd0)) act_nx[drv_q] = data_s2;
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      act_sh        <= '0;
      DRV_ACT_LED_N <= '1;
      FRAME_OK      <= 1'b0;
      FRAME_ERR     <= 1'b0;
      LINK_UP       <= 1'b0;
    end else begin
      act_sh    <= act_nx;
      FRAME_OK  <= commit;
      FRAME_ERR <= err;
      if (timeout_hit) begin
        LINK_UP       <= 1'b0;
        DRV_ACT_LED_N <= '1;
      end else if (commit) begin
        LINK_UP       <= 1'b1;
        DRV_ACT_LED_N <= ~act_nx;
      end
    end
  end

`ifdef SGPIO_LOCFAIL_EN
  logic [HDD_NUM-1:0] loc_sh, loc_nx, fail_sh, fail_nx;

  always_comb begin
    loc_nx  = loc_sh;
    fail_nx = fail_sh;
    if (store && (fld_q == 2'd1)) loc_nx[drv_q]  = data_s2;
    if (store && (fld_q == 2'd2)) fail_nx[drv_q] = data_s2;
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      loc_sh         <= '0;
      fail_sh        <= '0;
      DRV_LOC_LED_N  <= '1;
      DRV_FAIL_LED_N <= '1;
    end else begin
      loc_sh  <= loc_nx;
      fail_sh <= fail_nx;
      if (timeout_hit) begin
        DRV_LOC_LED_N  <= '1;
        DRV_FAIL_LED_N <= '1;
      end else if (commit) begin
        DRV_LOC_LED_N  <= ~loc_nx;
        DRV_FAIL_LED_N <= ~fail_nx;
      end
    end
  end
`else
  assign DRV_LOC_LED_N  = '1;
  assign DRV_FAIL_LED_N = '1;
`endif

endmodule
